// File: rtl/fp_addsub_special_pipe.sv
// Pipelined IEEE-754 add/sub special-case resolver: classifies operands at issue, carries the
// verdict down LAT-1 stages, and picks either the core adder result or the special result.
module fp_addsub_special_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int LAT   = 2,
  parameter int FTZ   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   core_s,
  output logic                   pipe_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   s,
  output logic                   flag_invalid,
  output logic                   flag_special
);

  localparam int           W      = 1 + EXP_W + MAN_W;
  localparam bit           FTZ_ON = (FTZ != 0);
  localparam logic [W-1:0] QNAN   = {1'b0, {(W-1){1'b1}}};

  if (LAT < 1 || LAT > 8) begin : g_lat_check
    $error("LAT must be in 1..8");
  end

  typedef struct packed {
    logic         special;
    logic         invalid;
    logic [W-1:0] res;
  } cls_t;

  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic             sa, sb;
  logic [W-1:0]     b_eff;
  cls_t             in_cls;
  cls_t             last_cls;
  logic             last_valid;

  assign a_exp = a[W-2 -: EXP_W];
  assign b_exp = b[W-2 -: EXP_W];
  assign a_man = a[MAN_W-1:0];
  assign b_man = b[MAN_W-1:0];
  assign sa    = a[W-1];
  assign sb    = b[W-1] ^ op;
  assign b_eff = {sb, b[W-2:0]};

  assign a_nan  = (&a_exp) && (|a_man);
  assign b_nan  = (&b_exp) && (|b_man);
  assign a_inf  = (&a_exp) && !(|a_man);
  assign b_inf  = (&b_exp) && !(|b_man);
  assign a_zero = !(|a_exp) && (!(|a_man) || FTZ_ON);
  assign b_zero = !(|b_exp) && (!(|b_man) || FTZ_ON);

  // Priority chain: NaN, Inf/Inf, single Inf, zero/zero, single zero, else the core result.
  always_comb begin
    // NOTE: every field gets a default before the if-chain, so no path leaves a latch behind.
    in_cls = '{special: 1'b1, invalid: 1'b0, res: '0};
    if (a_nan || b_nan) begin
      in_cls.invalid = 1'b1;
      in_cls.res     = QNAN;
    end else if (a_inf && b_inf) begin
      if (sa == sb) begin
        in_cls.res = a;
      end else begin
        in_cls.invalid = 1'b1;
        in_cls.res     = QNAN;
      end
    end else if (a_inf) begin
      in_cls.res = a;
    end else if (b_inf) begin
      in_cls.res = b_eff;
    end else if (a_zero && b_zero) begin
      in_cls.res = {sa & sb, {(W-1){1'b0}}};
    end else if (a_zero) begin
      in_cls.res = b_eff;
    end else if (b_zero) begin
      in_cls.res = a;
    end else begin
      in_cls.special = 1'b0;
    end
  end

  assign pipe_en  = !out_valid || out_ready;
  assign in_ready = pipe_en;

  if (LAT == 1) begin : g_comb
    assign last_valid = in_valid;
    assign last_cls   = in_cls;
  end else begin : g_pipe
    logic [LAT-2:0] vld_q;
    cls_t           cls_q [LAT-1];

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
      end else if (flush) begin
        vld_q <= '0;
      end else if (pipe_en) begin
        vld_q[0] <= in_valid;
        for (int i = 1; i < LAT - 1; i++) vld_q[i] <= vld_q[i-1];
      end
    end

    // NOTE: payload registers carry no reset; the valid bits alone say whether they mean anything.
    always_ff @(posedge clk) begin
      if (pipe_en) begin
        cls_q[0] <= in_cls;
        for (int i = 1; i < LAT - 1; i++) cls_q[i] <= cls_q[i-1];
      end
    end

    assign last_valid = vld_q[LAT-2];
    assign last_cls   = cls_q[LAT-2];
  end

  // Output register: the LAT-th advance; holds whole while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      s            <= '0;
      flag_invalid <= 1'b0;
      flag_special <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pipe_en) begin
      out_valid <= last_valid;
      if (last_valid) begin
        s            <= last_cls.special ? last_cls.res : core_s;
        flag_invalid <= last_cls.invalid;
        flag_special <= last_cls.special;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_special_pipe.sv
// Bench for fp_addsub_special_pipe: FTZ=0 and FTZ=1 instances share stimulus; a scoreboard
// queue holds model results pushed on acceptance and compared when each result transfers.
module tb_fp_addsub_special_pipe;

  localparam logic [31:0] QNAN = 32'h7FFF_FFFF;

  typedef struct packed {
    logic [31:0] s;
    logic        inv;
    logic        spec;
  } res_t;

  typedef struct packed {
    res_t e0;
    res_t e1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        op = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] core_s = '0;
  logic [31:0] next_core = '0;
  logic [31:0] core_pend = '0;

  logic        in_ready, pipe_en, out_valid, flag_invalid, flag_special;
  logic [31:0] s;
  logic        in_ready_f, pipe_en_f, out_valid_f, flag_invalid_f, flag_special_f;
  logic [31:0] s_f;

  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  fp_addsub_special_pipe #(.EXP_W(8), .MAN_W(23), .LAT(2), .FTZ(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .core_s(core_s), .pipe_en(pipe_en), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .flag_invalid(flag_invalid), .flag_special(flag_special)
  );

  fp_addsub_special_pipe #(.EXP_W(8), .MAN_W(23), .LAT(2), .FTZ(1)) dut_ftz (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_f),
    .a(a), .b(b), .op(op), .core_s(core_s), .pipe_en(pipe_en_f), .out_valid(out_valid_f),
    .out_ready(out_ready), .s(s_f), .flag_invalid(flag_invalid_f), .flag_special(flag_special_f)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  function automatic res_t model(input logic [31:0] ma, input logic [31:0] mb, input logic mop,
                                 input logic [31:0] mcore, input bit ftz);
    logic        msb;
    logic [31:0] mbp;
    logic        an, bn, ai, bi, az, bz;
    res_t        r;
    msb = mb[31] ^ mop;
    mbp = {msb, mb[30:0]};
    an  = (ma[30:23] == 8'hFF) && (ma[22:0] != 0);
    bn  = (mb[30:23] == 8'hFF) && (mb[22:0] != 0);
    ai  = (ma[30:23] == 8'hFF) && (ma[22:0] == 0);
    bi  = (mb[30:23] == 8'hFF) && (mb[22:0] == 0);
    az  = (ma[30:23] == 8'h00) && ((ma[22:0] == 0) || ftz);
    bz  = (mb[30:23] == 8'h00) && ((mb[22:0] == 0) || ftz);
    r   = '{s: mcore, inv: 1'b0, spec: 1'b0};
    if (an || bn)          r = '{s: QNAN, inv: 1'b1, spec: 1'b1};
    else if (ai && bi)     r = (ma[31] == msb) ? '{s: ma, inv: 1'b0, spec: 1'b1}
                                               : '{s: QNAN, inv: 1'b1, spec: 1'b1};
    else if (ai)           r = '{s: ma, inv: 1'b0, spec: 1'b1};
    else if (bi)           r = '{s: mbp, inv: 1'b0, spec: 1'b1};
    else if (az && bz)     r = '{s: {ma[31] & msb, 31'b0}, inv: 1'b0, spec: 1'b1};
    else if (az)           r = '{s: mbp, inv: 1'b0, spec: 1'b1};
    else if (bz)           r = '{s: ma, inv: 1'b0, spec: 1'b1};
    return r;
  endfunction

  // Scoreboard monitor, sampled mid-low-phase once stimulus has settled.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output s=%h with empty scoreboard", s);
        end else begin
          mon_e = sb_q.pop_front();
          n_checks++;
          if ({s, flag_invalid, flag_special} !== mon_e.e0)
            $display("FAIL result_ftz0 got s=%h inv=%b spec=%b want s=%h inv=%b spec=%b",
                     s, flag_invalid, flag_special, mon_e.e0.s, mon_e.e0.inv, mon_e.e0.spec);
          else n_pass++;
          n_checks++;
          if ({out_valid_f, s_f, flag_invalid_f, flag_special_f} !== {1'b1, mon_e.e1})
            $display("FAIL result_ftz1 got v=%b s=%h inv=%b spec=%b want v=1 s=%h inv=%b spec=%b",
                     out_valid_f, s_f, flag_invalid_f, flag_special_f,
                     mon_e.e1.s, mon_e.e1.inv, mon_e.e1.spec);
          else n_pass++;
        end
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready)
        sb_q.push_back('{e0: model(a, b, op, next_core, 1'b0), e1: model(a, b, op, next_core, 1'b1)});
      core_pend = in_ready ? (in_valid ? next_core : 32'h0) : core_s;
    end
  end

  // Core adder stand-in: its one internal stage follows the same advance enable.
  always @(posedge clk) core_s <= core_pend;

  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic top,
                      input logic [31:0] tcore);
    int guard;
    guard = 0;
    @(negedge clk);
    a = ta; b = tb; op = top; next_core = tcore; in_valid = 1'b1;
    #1;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL send_timeout in_ready=%b required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL %s_drain pending=%0d required 0", name, sb_q.size());
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL %s_idle out_valid=%b required 0", name, out_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid, out_valid_f} !== 2'b00) $display("FAIL reset_out_valid got %b required 00", {out_valid, out_valid_f});
    else n_pass++;
    n_checks++;
    if ({s, flag_invalid, flag_special} !== 34'h0) $display("FAIL reset_s got s=%h inv=%b spec=%b required zeros", s, flag_invalid, flag_special);
    else n_pass++;
    n_checks++;
    if ({in_ready, pipe_en} !== 2'b11) $display("FAIL reset_ready got in_ready=%b pipe_en=%b required 1 1", in_ready, pipe_en);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_inf_inf();
    send(32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h1111_1111);
    send(32'h7F80_0000, 32'h7F80_0000, 1'b0, 32'h2222_2222);
    drain("inf_inf");
  endtask

  task automatic test_signed_zero();
    send(32'h8000_0000, 32'h0000_0000, 1'b1, 32'h3333_3333);
    send(32'h8000_0000, 32'h0000_0000, 1'b0, 32'h4444_4444);
    drain("signed_zero");
  endtask

  task automatic test_passthrough();
    send(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL pass_early out_valid=%b required 0 one cycle after accept", out_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, s, flag_invalid, flag_special} !== {1'b1, 32'h4040_0000, 2'b00})
      $display("FAIL pass_latency got v=%b s=%h inv=%b spec=%b required v=1 s=40400000 flags 00",
               out_valid, s, flag_invalid, flag_special);
    else n_pass++;
    drain("passthrough");
  endtask

  task automatic test_ftz();
    send(32'h0000_0001, 32'h3F80_0000, 1'b1, 32'h1234_5678);
    @(posedge clk);
    #1;
    n_checks++;
    if ({s_f, flag_special_f} !== {32'hBF80_0000, 1'b1})
      $display("FAIL ftz_sub_a got s=%h spec=%b required BF800000 1", s_f, flag_special_f);
    else n_pass++;
    send(32'h8000_0001, 32'h0000_0003, 1'b1, 32'h5555_5555);
    drain("ftz");
  endtask

  logic [31:0] tab_a  [10] = '{32'h7FC0_0000, 32'h3F80_0000, 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000,
                               32'h0000_0000, 32'h4040_0000, 32'h8000_0000, 32'h7F80_0000, 32'h4120_0000};
  logic [31:0] tab_b  [10] = '{32'h3F80_0000, 32'hFF80_0001, 32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000,
                               32'hC000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0060_0000};
  logic        tab_op [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic test_special_table();
    for (int i = 0; i < 10; i++) send(tab_a[i], tab_b[i], tab_op[i], 32'h6000_0000 + i);
    drain("table");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4100_0000 + i);
      end
      begin
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
          @(negedge clk);
          k++;
        end
        repeat (3) begin
          #1;
          n_checks++;
          if ({out_valid, in_ready, pipe_en} !== 3'b100)
            $display("FAIL bp_stall got v=%b in_ready=%b pipe_en=%b required 1 0 0", out_valid, in_ready, pipe_en);
          else n_pass++;
          n_checks++;
          if (sb_q.size() == 0 || s !== sb_q[0].e0.s)
            $display("FAIL bp_hold got s=%h required head of scoreboard", s);
          else n_pass++;
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain("backpressure");
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    send(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h0A00_0001);
    send(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h0A00_0002);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL flush_clear cycle %0d out_valid=%b required 0", i, out_valid);
      else n_pass++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    a = 32'h3F80_0000; b = 32'h4000_0000; op = 1'b0; next_core = 32'h0B00_0000;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL flush_drop cycle %0d out_valid=%b required 0", i, out_valid);
      else n_pass++;
      @(posedge clk);
      #1;
    end
    send(32'h4000_0000, 32'h4000_0000, 1'b1, 32'h0C00_0000);
    drain("flush");
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    send(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h0D00_0001);
    send(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h0D00_0002);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, s, flag_invalid, flag_special} !== 35'h0)
      $display("FAIL rst_mid got v=%b s=%h inv=%b spec=%b required all zero", out_valid, s, flag_invalid, flag_special);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL rst_discard out_valid=%b required 0", out_valid);
      else n_pass++;
    end
    send(32'h4080_0000, 32'h3F80_0000, 1'b1, 32'h4040_0000);
    @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, s} !== {1'b1, 32'h4040_0000})
      $display("FAIL rst_after got v=%b s=%h required 1 40400000", out_valid, s);
    else n_pass++;
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_inf_inf();
    test_signed_zero();
    test_passthrough();
    test_ftz();
    test_special_table();
    test_backpressure();
    test_flush();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_addsub_special_pipe.md
Name: fp_addsub_special_pipe

Overview:
- Parametrised, pipelined special-case resolver for the floating-point add/sub unit. It is the successor of the combinational special-value selector.
- Classifies operands A and B, applies the add/sub operation to B's sign, and aligns the classification with the core adder result arriving LAT-1 stages later.
- Emits either the core result or the IEEE-correct special result, with exception flags, behind a valid/ready handshake.
- Sits between the operand issue logic and the result writeback. It drives the stall enable for the core adder pipeline.

Parameters:
- EXP_W, 8: exponent width.
- MAN_W, 23: mantissa width. Total width W = 1+EXP_W+MAN_W.
- LAT, 2: cycles from input acceptance to out_valid with no stall. Legal range 1..8.
- FTZ, 0: when 1, subnormal inputs are treated as signed zero.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; clears all valid bits.
- in_valid  in  1  operand transaction present.
- in_ready  out  1  transaction accepted when in_valid&&in_ready.
- a  in  W  operand A.
- b  in  W  operand B.
- op  in  1  0=add, 1=sub.
- core_s  in  W  core adder result for the transaction in the last internal stage.
- pipe_en  out  1  advance enable for the core adder pipeline.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- s  out  W  final result.
- flag_invalid  out  1  Inf-Inf with opposite effective signs, or any NaN operand.
- flag_special  out  1  result overridden (core_s not used).

Behaviour:
- Reset (rst_n=0, async) clears:
  - all stage valids, out_valid=0, s=0, flags=0;
  - in_ready and pipe_en follow the combinational rule below, so they read 1.
- Reset mid-operation discards all in-flight transactions; nothing is emitted for them.
- Stall rule:
  - pipe_en = !out_valid || out_ready; in_ready = pipe_en.
  - When pipe_en=0, every stage register and the output hold. No bubble collapse.
- Pipeline:
  - Stage 0 captures a, b, op, in_valid when pipe_en.
  - Stages advance one per pipe_en cycle.
  - The output register loads on the LAT-th advance, so a transaction appears on s exactly LAT cycles after acceptance absent stalls.
  - LAT=1: classification is combinational from the inputs and core_s is sampled in the same cycle.
- Sequencing: back-to-back acceptance is allowed (1 transaction/cycle). Order is preserved.
- flush: clears all stage valid bits and out_valid at the next edge. It overrides a simultaneous acceptance, which is dropped.
- Classification per operand (exp=exponent field, man=mantissa field):
  - NaN: exp all-ones, man≠0.
  - Inf: exp all-ones, man=0.
  - Zero: exp=0, man=0; or exp=0, man≠0 when FTZ=1 (sign retained).
  - Otherwise finite.
- Effective B sign sb = b[W-1]^op. B' = B with sign replaced by sb.
- Result selection, priority order:
  1. Any NaN: s = canonical NaN (sign 0, exp all-ones, man all-ones; 0x7FFFFFFF for defaults). flag_invalid=1, flag_special=1.
  2. Both Inf, sign(A)==sb: s=A, flag_special=1.
  3. Both Inf, sign(A)!=sb: s = canonical NaN, flag_invalid=1, flag_special=1.
  4. A Inf only: s=A. B' Inf only: s=B'. flag_special=1 in both cases.
  5. Both zero: s = -0 if sign(A)=1 and sb=1, else +0. flag_special=1.
  6. A zero only: s=B'. B zero only: s=A. flag_special=1 in both cases.
     - With FTZ=1, a flushed subnormal operand is returned as signed zero, never as its raw bits.
  7. Otherwise: s=core_s, flags=0.
- Output hold: s and the flags are stable while out_valid&&!out_ready.
- Simultaneous events: out_ready and in_valid in the same cycle with a full pipe: the output transfers and the new input is accepted in that cycle.

Test Plan:
- Inf-Inf: defaults, a=0x7F800000, b=0x7F800000, op=1 → after 2 cycles s=0x7FFFFFFF, flag_invalid=1, flag_special=1. Same with op=0 → s=0x7F800000, flag_invalid=0.
- Signed zero: a=0x80000000, b=0x00000000, op=1 → s=0x80000000. Same with op=0 → s=0x00000000.
- Normal pass-through: a=0x3F800000, b=0x40000000, op=0, core_s=0x40400000 presented when the transaction reaches the last stage → s=0x40400000, flags=0, exactly 2 cycles after acceptance.
- FTZ=1, subnormal A: a=0x00000001, b=0x3F800000, op=1 → s=0xBF800000, flag_special=1.
- Backpressure: 4 back-to-back transactions, out_ready=0 for 3 cycles → in_ready=pipe_en=0 while the output is held, s stable. Then all 4 results emerge in order with no loss or duplication.
- Reset/flush: assert rst_n=0 (or flush=1) with 2 transactions in flight → out_valid=0 next cycle, s=0 after reset. A later transaction completes normally with latency LAT.
